// File: rtl/sr_pulse_conditioner.sv
// sr_pulse_conditioner
//   Turns two raw, bouncing push-button inputs (set / clear) into clean,
//   mutually exclusive one-cycle strobes for an SR latch. It also keeps a
//   registered mirror of the latch state.
//
// Parameters
//   DB_CYCLES  consecutive mismatching cycles needed to flip a debounced level (2..255)
//   CNT_W      debounce counter width, DB_CYCLES <= 2**CNT_W - 1
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   set_btn   in   raw set button (asynchronous, may bounce)
//   clr_btn   in   raw clear button (asynchronous, may bounce)
//   s_pulse   out  one-cycle set strobe to latch S
//   r_pulse   out  one-cycle clear strobe to latch R
//   s_stable  out  debounced level of set_btn
//   r_stable  out  debounced level of clr_btn
//   state_q   out  registered mirror of the latch state
//   conflict  out  one-cycle flag: both debounced presses landed together
module sr_pulse_conditioner #(
   parameter int unsigned DB_CYCLES = 4,
   parameter int unsigned CNT_W     = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic set_btn,
   input  logic clr_btn,
   output logic s_pulse,
   output logic r_pulse,
   output logic s_stable,
   output logic r_stable,
   output logic state_q,
   output logic conflict
);

   localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);

   // Two-flop synchronisers
   logic s_sync1_q, s_sync2_q;
   logic r_sync1_q, r_sync2_q;

   // Debouncers
   logic [CNT_W-1:0] s_cnt_q, s_cnt_d;
   logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
   logic             s_stable_q, s_stable_d;
   logic             r_stable_q, r_stable_d;

   // Pulse / interlock / mirror
   logic s_rise, r_rise;
   logic s_pulse_q, s_pulse_d;
   logic r_pulse_q, r_pulse_d;
   logic conflict_q, conflict_d;
   logic state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_sync1_q <= 1'b0;
         s_sync2_q <= 1'b0;
         r_sync1_q <= 1'b0;
         r_sync2_q <= 1'b0;
      end else begin
         s_sync1_q <= set_btn;
         s_sync2_q <= s_sync1_q;
         r_sync1_q <= clr_btn;
         r_sync2_q <= r_sync1_q;
      end
   end

   // A sample matching the stable level restarts the count, so any bounce
   // back to the old level throws away the partial run.
   always_comb begin
      s_cnt_d    = s_cnt_q;
      s_stable_d = s_stable_q;
      if (s_sync2_q == s_stable_q) begin
         s_cnt_d = '0;
      end else if (s_cnt_q == DbLast) begin
         s_stable_d = s_sync2_q;
         s_cnt_d    = '0;
      end else begin
         s_cnt_d = s_cnt_q + 1'b1;
      end
   end

   always_comb begin
      r_cnt_d    = r_cnt_q;
      r_stable_d = r_stable_q;
      if (r_sync2_q == r_stable_q) begin
         r_cnt_d = '0;
      end else if (r_cnt_q == DbLast) begin
         r_stable_d = r_sync2_q;
         r_cnt_d    = '0;
      end else begin
         r_cnt_d = r_cnt_q + 1'b1;
      end
   end

   // Pulses are registered on the same edge the stable level rises, so they
   // are derived from the next-state of the stable registers.
   always_comb begin
      s_rise     = ~s_stable_q & s_stable_d;
      r_rise     = ~r_stable_q & r_stable_d;
      // Clear wins when both presses land together.
      r_pulse_d  = r_rise;
      s_pulse_d  = s_rise & ~r_rise;
      conflict_d = s_rise & r_rise;
      state_d    = state_q;
      if (r_pulse_d) begin
         state_d = 1'b0;
      end else if (s_pulse_d) begin
         state_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_cnt_q    <= '0;
         r_cnt_q    <= '0;
         s_stable_q <= 1'b0;
         r_stable_q <= 1'b0;
         s_pulse_q  <= 1'b0;
         r_pulse_q  <= 1'b0;
         conflict_q <= 1'b0;
         state_q    <= 1'b0;
      end else begin
         s_cnt_q    <= s_cnt_d;
         r_cnt_q    <= r_cnt_d;
         s_stable_q <= s_stable_d;
         r_stable_q <= r_stable_d;
         s_pulse_q  <= s_pulse_d;
         r_pulse_q  <= r_pulse_d;
         conflict_q <= conflict_d;
         state_q    <= state_d;
      end
   end

   assign s_pulse  = s_pulse_q;
   assign r_pulse  = r_pulse_q;
   assign s_stable = s_stable_q;
   assign r_stable = r_stable_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_pulse_conditioner.sv
// Testbench for sr_pulse_conditioner. Directed stimulus in one initial block;
// every expected strobe is pushed to a scoreboard when a button is driven and
// popped by a negedge monitor when the DUT raises a strobe. Level outputs are
// checked inline.
module tb_sr_pulse_conditioner;

   localparam int unsigned DB  = 4;
   localparam int          LAT = DB + 2;

   logic clk = 1'b0;
   logic rst;
   logic set_btn, clr_btn;
   logic s_pulse, r_pulse, s_stable, r_stable, state_q, conflict;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Expected strobe: cycle it appears in and {s_pulse, r_pulse, conflict}.
   typedef struct {
      int         cyc;
      logic [2:0] vec;
   } ev_t;
   ev_t sb[$];

   sr_pulse_conditioner #(
      .DB_CYCLES(DB),
      .CNT_W    (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .set_btn (set_btn),
      .clr_btn (clr_btn),
      .s_pulse (s_pulse),
      .r_pulse (r_pulse),
      .s_stable(s_stable),
      .r_stable(r_stable),
      .state_q (state_q),
      .conflict(conflict)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed {s,r,c}=%b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expect a strobe LAT edges after a button change driven now.
   task automatic push_ev(input logic [2:0] vec);
      ev_t e;
      e.cyc = cyc + LAT;
      e.vec = vec;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk_vec({tag, "_pulses"}, {s_pulse, r_pulse, conflict}, 3'b000);
      chk_bit({tag, "_s_stable"}, s_stable, 1'b0);
      chk_bit({tag, "_r_stable"}, r_stable, 1'b0);
      chk_bit({tag, "_state_q"}, state_q, 1'b0);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      ev_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         chk_int("missed_pulse", cyc, e.cyc);
      end
      if (s_pulse | r_pulse | conflict) begin
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk_vec("pulse_kind", {s_pulse, r_pulse, conflict}, e.vec);
         end else begin
            chk_vec("unexpected_pulse", {s_pulse, r_pulse, conflict}, 3'b000);
         end
      end
      chk_bit("latch_mutex", s_pulse & r_pulse, 1'b0);
   end

   initial begin
      rst     = 1'b1;
      set_btn = 1'b0;
      clr_btn = 1'b0;
      tick(3);
      chk_all_zero("reset");
      rst = 1'b0;
      tick(3);

      // Clean set press.
      push_ev(3'b100);
      set_btn = 1'b1;
      tick(LAT - 1);
      chk_bit("clean_early_s_pulse", s_pulse, 1'b0);
      chk_bit("clean_early_s_stable", s_stable, 1'b0);
      tick(1);
      chk_bit("clean_s_pulse", s_pulse, 1'b1);
      chk_bit("clean_s_stable", s_stable, 1'b1);
      chk_bit("clean_state_q", state_q, 1'b1);
      tick(1);
      chk_bit("clean_pulse_width", s_pulse, 1'b0);
      chk_bit("clean_state_hold", state_q, 1'b1);
      set_btn = 1'b0;
      tick(LAT + 2);
      chk_bit("release_s_stable", s_stable, 1'b0);
      chk_bit("release_state_q", state_q, 1'b1);

      // Bounce rejection: three short highs, then a held press.
      repeat (3) begin
         set_btn = 1'b1;
         tick(3);
         set_btn = 1'b0;
         tick(2);
      end
      chk_bit("bounce_s_stable", s_stable, 1'b0);
      push_ev(3'b100);
      set_btn = 1'b1;
      tick(LAT);
      chk_bit("bounce_s_pulse", s_pulse, 1'b1);
      set_btn = 1'b0;
      tick(LAT + 2);

      // Simultaneous press with state_q = 1: clear wins and flags conflict.
      chk_bit("simul_pre_state", state_q, 1'b1);
      push_ev(3'b011);
      set_btn = 1'b1;
      clr_btn = 1'b1;
      tick(LAT);
      chk_bit("simul_r_pulse", r_pulse, 1'b1);
      chk_bit("simul_s_pulse", s_pulse, 1'b0);
      chk_bit("simul_conflict", conflict, 1'b1);
      chk_bit("simul_state_q", state_q, 1'b0);
      tick(1);
      chk_bit("simul_conflict_width", conflict, 1'b0);

      // Long hold of both buttons: no further strobes.
      tick(100);
      chk_bit("hold_s_stable", s_stable, 1'b1);
      chk_bit("hold_r_stable", r_stable, 1'b1);
      chk_bit("hold_state_q", state_q, 1'b0);
      set_btn = 1'b0;
      clr_btn = 1'b0;
      tick(LAT + 2);

      // Set, release, wait, then clear.
      push_ev(3'b100);
      set_btn = 1'b1;
      tick(LAT + 2);
      chk_bit("sc_state_set", state_q, 1'b1);
      set_btn = 1'b0;
      tick(10);
      push_ev(3'b010);
      clr_btn = 1'b1;
      tick(LAT);
      chk_bit("sc_r_pulse", r_pulse, 1'b1);
      chk_bit("sc_state_clr", state_q, 1'b0);
      clr_btn = 1'b0;
      tick(LAT + 2);
      chk_bit("sc_release_state", state_q, 0);
      chk_bit("sc_release_r_stable", r_stable, 1'b0);

      // Bring state_q to 1 so the reset check below has something to clear.
      push_ev(3'b100);
      set_btn = 1'b1;
      tick(LAT + 2);
      set_btn = 1'b0;
      tick(LAT + 2);
      chk_bit("pre_rst_state", state_q, 1'b1);

      // Reset mid-count with the button held.
      set_btn = 1'b1;
      tick(4);
      rst = 1'b1;
      #1;
      chk_all_zero("mid_rst");
      tick(2);
      chk_all_zero("mid_rst_held");
      rst = 1'b0;
      push_ev(3'b100);
      tick(LAT - 1);
      chk_bit("post_rst_early", s_pulse, 1'b0);
      tick(1);
      chk_bit("post_rst_s_pulse", s_pulse, 1'b1);
      chk_bit("post_rst_state", state_q, 1'b1);
      set_btn = 1'b0;
      tick(LAT + 4);

      chk_int("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
